// File: rtl/stm1_tx_framer.sv
// STM-1 byte-parallel transmit framer: frame timing master, A1/A2/B1/B2 insertion, frame-synchronous scrambler.
// Define STM1TX_B2INS_EN to build the BIP-24 (B2) accumulators and overwrite row 4 cols 0-2 with B2.
module stm1_tx_framer #(
  parameter logic [7:0] A1VAL = 8'hF6,
  parameter logic [7:0] A2VAL = 8'h28
) (
  input  logic       clk19,
  input  logic       rst19,
  input  logic [7:0] pdi,
  output logic       sofreq,
  output logic [7:0] pdo,
  output logic       sofo
);

  // One clock of the x^7+x^6+1 scrambler, 8 bits MSB first: returns {next_state, key_byte}.
  function automatic logic [14:0] scr_step(input logic [6:0] s);
    logic [6:0] st;
    logic [7:0] key;
    st = s;
    for (int i = 7; i >= 0; i--) begin
      key[i] = st[6];
      st     = {st[5:0], st[6] ^ st[5]};
    end
    return {st, key};
  endfunction

  logic [3:0] r_row;
  logic [8:0] r_col;
  logic       w_sof_pos;

  logic [7:0] r_b1_acc;
  logic [7:0] r_b1_latch;

  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) begin
      r_row <= 4'd0;
      r_col <= 9'd0;
    end else if (r_col == 9'd269) begin
      r_col <= 9'd0;
      r_row <= (r_row == 4'd8) ? 4'd0 : r_row + 4'd1;
    end else begin
      r_col <= r_col + 9'd1;
    end
  end

  assign w_sof_pos = (r_row == 4'd0) && (r_col == 9'd0);
  assign sofreq    = w_sof_pos;

`ifdef STM1TX_B2INS_EN
  logic [1:0]  r_k;
  logic [1:0]  r_s1_k;
  logic [23:0] r_b2_acc;
  logic [23:0] r_b2_latch;
  logic [7:0]  w_b2_ins;
  logic        w_b2_incl;
  logic [23:0] w_b2_contrib;

  // Column modulo 3 selects the BIP-24 lane; 270 is a multiple of 3 so lanes realign every row.
  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) begin
      r_k <= 2'd0;
    end else if (r_col == 9'd269 || r_k == 2'd2) begin
      r_k <= 2'd0;
    end else begin
      r_k <= r_k + 2'd1;
    end
  end

  always_comb begin
    case (r_col[1:0])
      2'd0:    w_b2_ins = r_b2_latch[7:0];
      2'd1:    w_b2_ins = r_b2_latch[15:8];
      default: w_b2_ins = r_b2_latch[23:16];
    endcase
  end
`endif

  logic [7:0] w_s1_byte;

  always_comb begin
    w_s1_byte = pdi;
    if (r_row == 4'd0 && r_col < 9'd3)
      w_s1_byte = A1VAL;
    else if (r_row == 4'd0 && r_col < 9'd6)
      w_s1_byte = A2VAL;
    else if (r_row == 4'd1 && r_col == 9'd0)
      w_s1_byte = r_b1_latch;
`ifdef STM1TX_B2INS_EN
    else if (r_row == 4'd4 && r_col < 9'd3)
      w_s1_byte = w_b2_ins;
`endif
  end

  // Stage 1: overhead-inserted byte plus the frame position it belongs to.
  logic [7:0] r_s1_byte;
  logic [3:0] r_s1_row;
  logic [8:0] r_s1_col;
  logic       r_s1_vld;

  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) begin
      r_s1_byte <= 8'h00;
      r_s1_row  <= 4'd0;
      r_s1_col  <= 9'd0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s1_byte <= w_s1_byte;
      r_s1_row  <= r_row;
      r_s1_col  <= r_col;
      r_s1_vld  <= 1'b1;
    end
  end

`ifdef STM1TX_B2INS_EN
  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) r_s1_k <= 2'd0;
    else        r_s1_k <= r_k;
  end
`endif

  logic        w_s1_sof;
  logic        w_scr_bypass;
  logic        w_scr_start;
  logic [6:0]  r_scr;
  logic [6:0]  w_seed;
  logic [14:0] w_scr;
  logic [7:0]  w_pdo_next;

  assign w_s1_sof     = r_s1_vld && (r_s1_row == 4'd0) && (r_s1_col == 9'd0);
  assign w_scr_bypass = (r_s1_row == 4'd0) && (r_s1_col < 9'd9);
  assign w_scr_start  = (r_s1_row == 4'd0) && (r_s1_col == 9'd9);
  assign w_seed       = w_scr_start ? 7'h7F : r_scr;
  assign w_scr        = scr_step(w_seed);
  assign w_pdo_next   = w_scr_bypass ? r_s1_byte : (r_s1_byte ^ w_scr[7:0]);

  // Stage 2: scrambled output; frame-end latch and accumulator reload share the first-byte cycle.
  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) begin
      pdo        <= 8'h00;
      sofo       <= 1'b0;
      r_scr      <= 7'h7F;
      r_b1_acc   <= 8'h00;
      r_b1_latch <= 8'h00;
    end else begin
      pdo  <= w_pdo_next;
      sofo <= w_s1_sof;
      if (!w_scr_bypass)
        r_scr <= w_scr[14:8];
      if (r_s1_vld) begin
        r_b1_acc <= (w_s1_sof ? 8'h00 : r_b1_acc) ^ w_pdo_next;
        if (w_s1_sof)
          r_b1_latch <= r_b1_acc;
      end
    end
  end

`ifdef STM1TX_B2INS_EN
  assign w_b2_incl = !((r_s1_row < 4'd3) && (r_s1_col < 9'd9));

  always_comb begin
    w_b2_contrib = 24'h0;
    if (w_b2_incl) begin
      case (r_s1_k)
        2'd0:    w_b2_contrib = {16'h0, r_s1_byte};
        2'd1:    w_b2_contrib = {8'h0, r_s1_byte, 8'h0};
        default: w_b2_contrib = {r_s1_byte, 16'h0};
      endcase
    end
  end

  always_ff @(posedge clk19 or negedge rst19) begin
    if (!rst19) begin
      r_b2_acc   <= 24'h0;
      r_b2_latch <= 24'h0;
    end else if (r_s1_vld) begin
      r_b2_acc <= (w_s1_sof ? 24'h0 : r_b2_acc) ^ w_b2_contrib;
      if (w_s1_sof)
        r_b2_latch <= r_b2_acc;
    end
  end
`endif

endmodule

// File: tb/tb_stm1_tx_framer.sv
// Directed bench for stm1_tx_framer: framing, scrambler, B1, B2 (or pass-through), mid-frame reset.
module tb_stm1_tx_framer;
  localparam int FL = 2430;
  localparam int NC = 2 * FL + 2;

  logic       clk19 = 1'b0;
  logic       rst19 = 1'b0;
  logic [7:0] pdi   = 8'h00;
  logic       sofreq;
  logic [7:0] pdo;
  logic       sofo;

  always #5 clk19 = ~clk19;

  stm1_tx_framer dut (
    .clk19 (clk19),
    .rst19 (rst19),
    .pdi   (pdi),
    .sofreq(sofreq),
    .pdo   (pdo),
    .sofo  (sofo)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] stim      [0:NC-1];
  logic [7:0] pdo_cap   [0:NC-1];
  logic       sofo_cap  [0:NC-1];
  logic       sofreq_cap[0:NC-1];
  logic [7:0] exp_pdo   [0:2*FL-1];
  logic [7:0] exp_pre   [0:2*FL-1];
  logic [7:0] ks        [0:FL-1];
  bit         sbits     [0:19367];

  // Keystream per frame position, from the recurrence a[n] = a[n-7] ^ a[n-6] seeded with seven ones.
  task build_ks;
    for (int i = 0; i < 7; i++) sbits[i] = 1'b1;
    for (int i = 7; i < 19368; i++) sbits[i] = sbits[i-7] ^ sbits[i-6];
    for (int p = 0; p < 9; p++) ks[p] = 8'h00;
    for (int p = 9; p < FL; p++)
      for (int b = 0; b < 8; b++) ks[p][7-b] = sbits[(p-9)*8 + b];
  endtask

  // Expected output of two frames after reset, given stim.
  task model2;
    logic [7:0] b1, b1_ins, pre, o;
    logic [7:0] b2 [3];
    logic [7:0] b2_ins [3];
    int row, col;
    b1 = 8'h00;
    for (int k = 0; k < 3; k++) b2[k] = 8'h00;
    for (int f = 0; f < 2; f++) begin
      b1_ins = b1;
      for (int k = 0; k < 3; k++) begin b2_ins[k] = b2[k]; b2[k] = 8'h00; end
      b1 = 8'h00;
      for (int p = 0; p < FL; p++) begin
        row = p / 270;
        col = p % 270;
        pre = stim[f*FL + p];
        if (row == 0 && col < 3) pre = 8'hF6;
        else if (row == 0 && col < 6) pre = 8'h28;
        else if (row == 1 && col == 0) pre = b1_ins;
`ifdef STM1TX_B2INS_EN
        else if (row == 4 && col < 3) pre = b2_ins[col];
`endif
        o = pre ^ ks[p];
        exp_pre[f*FL + p] = pre;
        exp_pdo[f*FL + p] = o;
        b1 = b1 ^ o;
        if (!(row < 3 && col < 9)) b2[col % 3] = b2[col % 3] ^ pre;
      end
    end
  endtask

  task run(input int n);
    for (int c = 0; c < n; c++) begin
      pdi = stim[c];
      #1;
      sofreq_cap[c] = sofreq;
      @(posedge clk19);
      #1;
      pdo_cap[c]  = pdo;
      sofo_cap[c] = sofo;
    end
  endtask

  task restart;
    rst19 = 1'b0;
    repeat (2) @(posedge clk19);
    @(negedge clk19);
    rst19 = 1'b1;
  endtask

  task compare_frame(input int f, input string name);
    int errs, first;
    errs = 0;
    first = -1;
    for (int p = 0; p < FL; p++)
      if (pdo_cap[f*FL + p + 1] !== exp_pdo[f*FL + p]) begin
        errs++;
        if (first < 0) first = p;
      end
    n_total++;
    if (errs !== 0)
      $display("FAIL %s: %0d bytes differ, first at pos %0d got %h want %h", name, errs, first,
               pdo_cap[f*FL + first + 1], exp_pdo[f*FL + first]);
    else n_pass++;
  endtask

  task test_reset;
    rst19 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pdi = 8'h5A ^ 8'(i);
      @(posedge clk19);
      #1;
      n_total++;
      if (pdo !== 8'h00 || sofo !== 1'b0)
        $display("FAIL reset_out: pdo %h sofo %b, want 00 0", pdo, sofo);
      else n_pass++;
    end
  endtask

  task test_framing;
    logic [7:0] hdr [9];
    logic [7:0] scr [8];
    hdr = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28, 8'h00, 8'h00, 8'h00};
    scr = '{8'hFE, 8'h04, 8'h18, 8'h51, 8'hE4, 8'h59, 8'hD4, 8'hFA};
    for (int c = 0; c < NC; c++) stim[c] = 8'h00;
    restart();
    run(NC);
    n_total++;
    if (sofreq_cap[0] !== 1'b1 || sofreq_cap[1] !== 1'b0) $display("FAIL sofreq_first: %b%b want 10", sofreq_cap[0], sofreq_cap[1]);
    else n_pass++;
    n_total++;
    if (sofreq_cap[FL-1] !== 1'b0 || sofreq_cap[FL] !== 1'b1) $display("FAIL sofreq_period: %b%b want 01", sofreq_cap[FL-1], sofreq_cap[FL]);
    else n_pass++;
    n_total++;
    if (sofo_cap[0] !== 1'b0 || sofo_cap[1] !== 1'b1 || sofo_cap[2] !== 1'b0) $display("FAIL sofo_first: %b%b%b want 010", sofo_cap[0], sofo_cap[1], sofo_cap[2]);
    else n_pass++;
    n_total++;
    if (sofo_cap[FL+1] !== 1'b1) $display("FAIL sofo_period: %b want 1", sofo_cap[FL+1]);
    else n_pass++;
    for (int p = 0; p < 9; p++) begin
      n_total++;
      if (pdo_cap[p+1] !== hdr[p]) $display("FAIL header_%0d: got %h want %h", p, pdo_cap[p+1], hdr[p]);
      else n_pass++;
    end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (pdo_cap[f*FL + 9 + i + 1] !== scr[i])
          $display("FAIL scr_f%0d_%0d: got %h want %h", f, i, pdo_cap[f*FL + 9 + i + 1], scr[i]);
        else n_pass++;
      end
    model2();
    compare_frame(0, "zero_frame1");
    compare_frame(1, "zero_frame2");
  endtask

  task test_b1;
    logic [7:0] pre;
    for (int c = 0; c < NC; c++) stim[c] = 8'($urandom);
    restart();
    run(NC);
    model2();
    compare_frame(0, "rand_frame1");
    compare_frame(1, "rand_frame2");
    pre = pdo_cap[270 + 1] ^ ks[270];
    n_total++;
    if (pre !== 8'h00) $display("FAIL b1_first_frame: got %h want 00", pre);
    else n_pass++;
    pre = pdo_cap[FL + 270 + 1] ^ ks[270];
    n_total++;
    if (pre !== exp_pre[FL + 270]) $display("FAIL b1_second_frame: got %h want %h", pre, exp_pre[FL + 270]);
    else n_pass++;
  endtask

`ifdef STM1TX_B2INS_EN
  task test_b2;
    logic [7:0] want [3];
    logic [7:0] pre;
    want = '{8'h01, 8'h00, 8'h80};
    for (int c = 0; c < NC; c++) stim[c] = 8'h00;
    stim[3*270 + 9]  = 8'h01;
    stim[8*270 + 11] = 8'h80;
    restart();
    run(NC);
    for (int k = 0; k < 3; k++) begin
      pre = pdo_cap[FL + 4*270 + k + 1] ^ ks[4*270 + k];
      n_total++;
      if (pre !== want[k]) $display("FAIL b2_byte%0d: got %h want %h", k, pre, want[k]);
      else n_pass++;
    end
  endtask
`else
  task test_row4_pass;
    logic [7:0] pre;
    for (int c = 0; c < NC; c++) stim[c] = 8'h00;
    for (int k = 0; k < 3; k++) stim[4*270 + k] = 8'hA5;
    restart();
    run(NC);
    for (int k = 0; k < 3; k++) begin
      pre = pdo_cap[4*270 + k + 1] ^ ks[4*270 + k];
      n_total++;
      if (pre !== 8'hA5) $display("FAIL row4_pass_%0d: got %h want a5", k, pre);
      else n_pass++;
    end
  endtask
`endif

  task test_mid_reset;
    for (int c = 0; c < NC; c++) stim[c] = 8'($urandom);
    restart();
    run(5*270 + 100);
    rst19 = 1'b0;
    pdi = 8'hFF;
    #1;
    n_total++;
    if (pdo !== 8'h00 || sofo !== 1'b0 || sofreq !== 1'b1)
      $display("FAIL midreset_async: pdo %h sofo %b sofreq %b, want 00 0 1", pdo, sofo, sofreq);
    else n_pass++;
    repeat (2) begin
      @(posedge clk19);
      #1;
      n_total++;
      if (pdo !== 8'h00 || sofo !== 1'b0) $display("FAIL midreset_hold: pdo %h sofo %b, want 00 0", pdo, sofo);
      else n_pass++;
    end
    for (int c = 0; c < NC; c++) stim[c] = 8'($urandom);
    @(negedge clk19);
    rst19 = 1'b1;
    run(NC);
    model2();
    n_total++;
    if (sofreq_cap[0] !== 1'b1) $display("FAIL midreset_sofreq: got %b want 1", sofreq_cap[0]);
    else n_pass++;
    n_total++;
    if ((pdo_cap[270 + 1] ^ ks[270]) !== 8'h00)
      $display("FAIL midreset_b1: got %h want 00", pdo_cap[270 + 1] ^ ks[270]);
    else n_pass++;
    compare_frame(0, "midreset_frame1");
    compare_frame(1, "midreset_frame2");
  endtask

  initial begin
    build_ks();
    test_reset();
    test_framing();
    test_b1();
`ifdef STM1TX_B2INS_EN
    test_b2();
`else
    test_row4_pass();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
